// File: rtl/vehicle_request_gen.sv
`default_nettype none
// ============================================================================
// Module  : vehicle_request_gen
// Brief   : Conditions the country-road loop detector and generates the
//           car-waiting request x for the two-road traffic light controller.
// Revision: 1.0  initial release
// ============================================================================
module vehicle_request_gen #(
    parameter int DEBOUNCE  = 4,
    parameter int MIN_GREEN = 6,
    parameter int GAP       = 3,
    parameter int MAX_GREEN = 12,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_raw,
    input  logic [1:0]       country,
    output logic             x,
    output logic [CNT_W-1:0] waiting_count,
    output logic             serve_done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQUEST = 2'd1;
    localparam logic [1:0] S_SERVE   = 2'd2;
    localparam logic [1:0] S_CLEAR   = 2'd3;

    localparam logic [1:0]       C_GREEN     = 2'b00;
    localparam logic [1:0]       C_RED       = 2'b10;
    localparam logic [7:0]       C_DB_LAST   = 8'(DEBOUNCE - 1);
    localparam logic [7:0]       C_MING_LAST = 8'(MIN_GREEN - 1);
    localparam logic [7:0]       C_MAXG_LAST = 8'(MAX_GREEN - 1);
    localparam logic [7:0]       C_GAP       = 8'(GAP);
    localparam logic [7:0]       C_T_MAX     = 8'hFF;
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

    logic             r_s1, r_s2, r_deb, r_deb_q, r_pending;
    logic [7:0]       r_db_cnt, r_green_t, r_gap_t;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_x, r_done;

    logic       w_rise, w_exit, w_enter_serve;
    logic [1:0] w_next;

    assign w_rise        = r_deb & ~r_deb_q;
    assign w_exit        = (r_green_t == C_MAXG_LAST) ||
                           ((r_green_t >= C_MING_LAST) && (r_gap_t >= C_GAP));
    assign w_enter_serve = (r_state == S_REQUEST) && (w_next == S_SERVE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_rise) w_next = S_REQUEST;
            S_REQUEST: if (country == C_GREEN) w_next = S_SERVE;
            S_SERVE:   if (w_exit) w_next = S_CLEAR;
            // An arrival on the very edge country turns red still counts as pending.
            S_CLEAR:   if (country == C_RED) w_next = (r_pending | w_rise) ? S_REQUEST : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_deb     <= 1'b0;
            r_deb_q   <= 1'b0;
            r_db_cnt  <= 8'd0;
            r_state   <= S_IDLE;
            r_x       <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_green_t <= 8'd0;
            r_gap_t   <= 8'd0;
        end else begin
            r_s1    <= sensor_raw;
            r_s2    <= r_s1;
            r_deb_q <= r_deb;

            if (r_s2 == r_deb) begin
                r_db_cnt <= 8'd0;
            end else if (r_db_cnt == C_DB_LAST) begin
                r_deb    <= r_s2;
                r_db_cnt <= 8'd0;
            end else begin
                r_db_cnt <= r_db_cnt + 8'd1;
            end

            r_state <= w_next;
            r_x     <= (w_next == S_REQUEST) || (w_next == S_SERVE);
            r_done  <= (r_state == S_SERVE) && (w_next == S_CLEAR);

            // Entering service clears the count even if a vehicle arrives on that edge.
            if (w_enter_serve)
                r_cnt <= '0;
            else if (w_rise && (r_state != S_SERVE) && (r_cnt != C_CNT_MAX))
                r_cnt <= r_cnt + 1'b1;

            if ((r_state == S_CLEAR) && (w_next == S_CLEAR))
                r_pending <= r_pending | w_rise;
            else
                r_pending <= 1'b0;

            if (w_enter_serve) begin
                r_green_t <= 8'd0;
                r_gap_t   <= 8'd0;
            end else if (r_state == S_SERVE) begin
                if (r_green_t != C_T_MAX)
                    r_green_t <= r_green_t + 8'd1;
                if (r_deb)
                    r_gap_t <= 8'd0;
                else if (r_gap_t != C_T_MAX)
                    r_gap_t <= r_gap_t + 8'd1;
            end
        end
    end

    assign x             = r_x;
    assign waiting_count = r_cnt;
    assign serve_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vehicle_request_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vehicle_request_gen
// Brief   : Directed bench for vehicle_request_gen with a cycle-level
//           behavioural reference model and per-cycle output comparison.
// Revision: 1.0  initial release
// ============================================================================
module tb_vehicle_request_gen;

    localparam int DEBOUNCE  = 4;
    localparam int MIN_GREEN = 6;
    localparam int GAP       = 3;
    localparam int MAX_GREEN = 12;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             sensor_raw;
    logic [1:0]       country;
    logic             x;
    logic [CNT_W-1:0] waiting_count;
    logic             serve_done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    vehicle_request_gen #(
        .DEBOUNCE (DEBOUNCE),
        .MIN_GREEN(MIN_GREEN),
        .GAP      (GAP),
        .MAX_GREEN(MAX_GREEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor_raw   (sensor_raw),
        .country      (country),
        .x            (x),
        .waiting_count(waiting_count),
        .serve_done   (serve_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_WAIT = 1, M_SERVE = 2, M_CLEAR = 3;

    bit raw_hist[2];          // raw samples, [1] is the synchronised value
    bit s2_hist[DEBOUNCE];    // most recent synchronised samples, [0] newest
    bit m_deb, m_deb_q, m_pend, m_x, m_done;
    int m_mode, m_cnt, m_served, m_low_run;

    always @(posedge clk) begin
        bit s2_old, rise, deb_old, flip, leave;
        if (rst) begin
            raw_hist = '{default: 1'b0};
            s2_hist  = '{default: 1'b0};
            m_deb = 0; m_deb_q = 0; m_pend = 0; m_x = 0; m_done = 0;
            m_mode = M_IDLE; m_cnt = 0; m_served = 0; m_low_run = 0;
        end else begin
            s2_old  = raw_hist[1];
            deb_old = m_deb;
            rise    = m_deb && !m_deb_q;

            // Level follows s2 once the last DEBOUNCE samples all disagree with it.
            for (int i = DEBOUNCE - 1; i > 0; i--) s2_hist[i] = s2_hist[i-1];
            s2_hist[0] = s2_old;
            flip = 1'b1;
            for (int i = 0; i < DEBOUNCE; i++) if (s2_hist[i] == m_deb) flip = 1'b0;
            m_deb_q = m_deb;
            if (flip) m_deb = s2_old;
            raw_hist[1] = raw_hist[0];
            raw_hist[0] = sensor_raw;

            m_done = 0;
            if (rise && m_mode != M_SERVE && m_cnt < CNT_MAX) m_cnt++;
            case (m_mode)
                M_IDLE: if (rise) m_mode = M_WAIT;
                M_WAIT: if (country == 2'b00) begin
                    m_mode = M_SERVE; m_cnt = 0; m_served = 0; m_low_run = 0;
                end
                M_SERVE: begin
                    leave = (m_served == MAX_GREEN - 1) ||
                            (m_served >= MIN_GREEN - 1 && m_low_run >= GAP);
                    m_served++;
                    m_low_run = deb_old ? 0 : m_low_run + 1;
                    if (leave) begin m_mode = M_CLEAR; m_done = 1; end
                end
                default: begin
                    if (rise) m_pend = 1;
                    if (country == 2'b10) begin
                        m_mode = m_pend ? M_WAIT : M_IDLE;
                        m_pend = 0;
                    end
                end
            endcase
            m_x = (m_mode == M_WAIT) || (m_mode == M_SERVE);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_x", int'(x), int'(m_x));
            chk("model_count", int'(waiting_count), m_cnt);
            chk("model_done", int'(serve_done), int'(m_done));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect3(input string name, input int ex, input int ec, input int ed);
        chk({name, "_x"}, int'(x), ex);
        chk({name, "_count"}, int'(waiting_count), ec);
        chk({name, "_done"}, int'(serve_done), ed);
    endtask

    initial begin
        rst = 1'b1; sensor_raw = 1'b0; country = 2'b10;
        tick(2);
        expect3("reset", 0, 0, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Glitch of 3 cycles is rejected
        sensor_raw = 1'b1; tick(3);
        sensor_raw = 1'b0; tick(10);
        expect3("glitch", 0, 0, 0);

        // Clean arrival: x rises on the 7th edge
        sensor_raw = 1'b1; tick(6);
        expect3("req_edge6", 0, 0, 0);
        tick(1);
        expect3("req_edge7", 1, 1, 0);
        sensor_raw = 1'b0; tick(10);
        expect3("req_hold", 1, 1, 0);

        // Gap-out: green with detector empty
        country = 2'b00; tick(1);
        expect3("serve_entry", 1, 0, 0);
        tick(5);
        expect3("gap_edge5", 1, 0, 0);
        tick(1);
        expect3("gap_exit", 0, 0, 1);
        tick(1);
        expect3("gap_after", 0, 0, 0);

        // Arrival during yellow is remembered
        country = 2'b01; sensor_raw = 1'b1; tick(7);
        expect3("clear_arrival", 0, 1, 0);
        country = 2'b10; tick(1);
        expect3("pending_req", 1, 1, 0);

        // Max-green with detector occupied
        country = 2'b00; tick(1);
        expect3("max_entry", 1, 0, 0);
        tick(11);
        expect3("max_edge11", 1, 0, 0);
        tick(1);
        expect3("max_exit", 0, 0, 1);
        country = 2'b01; tick(2);
        country = 2'b10; tick(3);
        expect3("max_idle", 0, 0, 0);

        // Saturation after 20 arrivals, with a 2'b11 hold in between
        sensor_raw = 1'b0; tick(8);
        for (int i = 0; i < 20; i++) begin
            sensor_raw = 1'b1; tick(8);
            sensor_raw = 1'b0; tick(8);
        end
        expect3("saturate", 1, CNT_MAX, 0);
        country = 2'b11; tick(4);
        expect3("code11_hold", 1, CNT_MAX, 0);
        country = 2'b10;

        rst = 1'b1; tick(1);
        expect3("mid_reset", 0, 0, 0);
        rst = 1'b0; tick(4);
        expect3("post_reset", 0, 0, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vehicle_request_gen.md
Name: vehicle_request_gen

Overview:
Upstream stage of the two-road traffic light controller. It conditions the raw country-road loop detector and produces that controller's single-bit car-waiting request x.
- Synchronises and debounces the detector.
- Latches and counts arriving vehicles.
- Holds x while the country road is served, dropping it on gap-out or max-green.
- Watches the controller's country light code (GREEN=2'b00, YELLOW=2'b01, RED=2'b10) to track when service starts and ends.

Parameters:
DEBOUNCE, 4, consecutive cycles the synchronised input must differ before the debounced level changes (1..255)
MIN_GREEN, 6, minimum SERVE cycles before gap-out is allowed (1..255)
GAP, 3, consecutive debounced-low cycles that end service after MIN_GREEN (1..255)
MAX_GREEN, 12, hard limit on SERVE cycles (must be >= MIN_GREEN, <= 255)
CNT_W, 4, width of waiting_count

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
sensor_raw  in  1  asynchronous loop detector, high while a vehicle is present
country  in  2  country light code from the controller
x  out  1  request to the controller (registered)
waiting_count  out  CNT_W  vehicles arrived since last service (saturating)
serve_done  out  1  one-cycle strobe on SERVE->CLEAR

Behaviour:
- Reset (rst=1 at an edge): clears all flops. x=0, waiting_count=0, serve_done=0, state IDLE. Sync flops, debounced level deb, deb_q, pending and all timers go to 0. Reset mid-operation abandons any request immediately.
- Synchroniser: two flops, s1<=sensor_raw, s2<=s1.
- Debounce:
  - db_cnt increments each edge where s2!=deb; it clears when s2==deb.
  - At the DEBOUNCE-th consecutive differing edge, deb<=s2 and db_cnt<=0.
  - Pulses on s2 shorter than DEBOUNCE cycles are ignored.
- rise = deb & ~deb_q (combinational), where deb_q is deb delayed one cycle.
- Latency: a clean sensor_raw 0->1 that is stable before edge 1 makes deb=1 after edge 2+DEBOUNCE. From IDLE, x=1 after edge 3+DEBOUNCE (7 with defaults).
- FSM states, with x registered and decoded from next state:
  - IDLE (x=0): rise -> REQUEST.
  - REQUEST (x=1): country==2'b00 -> SERVE; else stay.
  - SERVE (x=1):
    - green_t clears on entry and increments each cycle in SERVE, saturating at 255.
    - gap_t counts consecutive cycles with deb==0 and clears whenever deb==1.
    - Exit to CLEAR when green_t==MAX_GREEN-1, or when (green_t>=MIN_GREEN-1 and gap_t>=GAP).
    - serve_done=1 for the cycle after the exit edge.
  - CLEAR (x=0): waits for the controller to finish country yellow. When country==2'b10 -> REQUEST if pending, else IDLE; pending clears on leaving.
  - country==2'b11 is treated as neither green nor red; the FSM holds state.
- Arrivals:
  - rise in IDLE, REQUEST or CLEAR increments waiting_count, saturating at 2^CNT_W-1.
  - rise in CLEAR also sets pending.
  - rise in SERVE is not counted; the vehicle is being served.
  - waiting_count clears at the edge entering SERVE. If rise coincides with that edge, the clear wins.
- If the controller never goes green, REQUEST holds x=1 indefinitely; there is no timeout.
- Illegal state encodings recover to IDLE on the next edge with x=0.

Test Plan:
1. Glitch rejection: rst 2 cycles, then sensor_raw=1 for 3 cycles and back to 0 -> deb stays 0, x stays 0, waiting_count=0.
2. Basic request: sensor_raw=1 held, country=2'b10 -> x=1 exactly 7 edges after the rise and waiting_count=1. Then drive country=2'b00 -> waiting_count=0 next edge, x stays 1.
3. Gap-out: in SERVE with sensor_raw=0 throughout -> x drops after green_t reaches 5 with gap_t>=3. Exit occurs at the 6th SERVE edge; serve_done pulses once, then x=0.
4. Max-green: in SERVE with sensor_raw held 1 -> exit at green_t=11, x=0 on the 12th SERVE edge. Drive country 00->01->10 -> IDLE.
5. Pending in CLEAR: a clean arrival while country=2'b01 -> waiting_count=1, x=0. On country=2'b10, x returns to 1 the next edge without a new arrival.
6. Saturation and reset: 20 clean arrivals in REQUEST -> waiting_count=15. Assert rst mid-REQUEST -> next edge x=0, waiting_count=0, IDLE.
